// File: rtl/unstriping.sv
// unstriping: two-lane receive-side re-interleaver.
// Per-lane skew FIFOs feed a strict lane-0 / lane-1 output order.
module unstriping #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk_2f,
  input  logic             reset,
  input  logic [WIDTH-1:0] lane_0,
  input  logic             valid_0,
  input  logic [WIDTH-1:0] lane_1,
  input  logic             valid_1,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             overflow,
  output logic             aligned
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] mem_q [2][DEPTH];
  logic [AW-1:0]    wp_q  [2];
  logic [AW-1:0]    rp_q  [2];
  logic [AW:0]      cnt_q [2];
  logic [AW:0]      cnt_d [2];
  logic [WIDTH-1:0] din   [2];

  logic [1:0]       skip_q, skip_d;
  logic             sel_q, sel_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             vout_q, vout_d;
  logic             ovf_q, ovf_d;

  logic [1:0] cap, acc, push, pop;
  logic [1:0] empty, full;
  logic       run;

  assign din[0] = lane_0;
  assign din[1] = lane_1;
  assign run    = (state_q == RUN);

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      empty[i] = (cnt_q[i] == '0);
      full[i]  = cnt_q[i][AW];
    end
    cap    = {valid_1, valid_0} & ~skip_q;
    skip_d = cap;
    // lane 1 only counts once lane 0 has opened the stream
    acc[0] = cap[0];
    acc[1] = cap[1] & (run | ~empty[0] | cap[0]);
    pop = '0;
    if (run) pop[sel_q] = ~empty[sel_q];
    push = acc & (~full | pop);
    for (int i = 0; i < 2; i++) begin
      unique case ({push[i], pop[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + 1'b1;
        2'b01:   cnt_d[i] = cnt_q[i] - 1'b1;
        default: cnt_d[i] = cnt_q[i];
      endcase
    end
    ovf_d  = ovf_q | (|(acc & ~push));
    sel_d  = sel_q ^ (|pop);
    vout_d = |pop;
    data_d = data_q;
    if (|pop) data_d = mem_q[sel_q][rp_q[sel_q]];
    state_d = state_q;
    unique case (state_q)
      IDLE: if (!empty[0]) state_d = RUN;
      RUN: begin
        if (!valid_0 && !valid_1 && (&empty) && !sel_q)
          state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_2f or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      skip_q  <= '0;
      sel_q   <= 1'b0;
      data_q  <= '0;
      vout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        wp_q[i]  <= '0;
        rp_q[i]  <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      vout_q  <= vout_d;
      ovf_q   <= ovf_d;
      for (int i = 0; i < 2; i++) begin
        if (push[i]) wp_q[i] <= wp_q[i] + 1'b1;
        if (pop[i])  rp_q[i] <= rp_q[i] + 1'b1;
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  always_ff @(posedge clk_2f) begin
    for (int i = 0; i < 2; i++) begin
      if (push[i]) mem_q[i][wp_q[i]] <= din[i];
    end
  end

  assign data_out  = data_q;
  assign valid_out = vout_q;
  assign overflow  = ovf_q;
  assign aligned   = run;

endmodule

// File: tb/tb_unstriping.sv
// tb_unstriping: randomized and directed checks of unstriping
// against a queue-based lane reference model.
module tb_unstriping;

  localparam int W = 32;
  localparam int D = 4;

  logic         clk_2f = 1'b0;
  logic         reset  = 1'b1;
  logic [W-1:0] lane_0 = '0;
  logic         valid_0 = 1'b0;
  logic [W-1:0] lane_1 = '0;
  logic         valid_1 = 1'b0;
  logic [W-1:0] data_out;
  logic         valid_out;
  logic         overflow;
  logic         aligned;

  always #5 clk_2f = ~clk_2f;

  unstriping #(.WIDTH(W), .DEPTH(D)) dut (
    .clk_2f   (clk_2f),
    .reset    (reset),
    .lane_0   (lane_0),
    .valid_0  (valid_0),
    .lane_1   (lane_1),
    .valid_1  (valid_1),
    .data_out (data_out),
    .valid_out(valid_out),
    .overflow (overflow),
    .aligned  (aligned)
  );

  int vec = 0;
  int err = 0;

  logic [W-1:0] mq0[$];
  logic [W-1:0] mq1[$];
  bit           m_sk0, m_sk1, m_run, m_sel, m_ovf, m_vout;
  logic [W-1:0] m_dout;

  bit           sv0[64];
  bit           sv1[64];
  logic [W-1:0] sd0[64];
  logic [W-1:0] sd1[64];
  logic [W-1:0] got[$];
  logic [W-1:0] exp_q[$];

  task automatic model_reset();
    mq0.delete();
    mq1.delete();
    m_sk0 = 0; m_sk1 = 0; m_run = 0;
    m_sel = 0; m_ovf = 0; m_vout = 0;
    m_dout = '0;
  endtask

  task automatic sched_clear();
    for (int c = 0; c < 64; c++) begin
      sv0[c] = 0; sv1[c] = 0;
      sd0[c] = '0; sd1[c] = '0;
    end
    got.delete();
    exp_q.delete();
  endtask

  task automatic put(input int lane, input int c, input logic [W-1:0] d);
    for (int k = 0; k < 2; k++) begin
      if (lane == 0) begin sv0[c+k] = 1; sd0[c+k] = d; end
      else begin sv1[c+k] = 1; sd1[c+k] = d; end
    end
  endtask

  task automatic stream(input logic [W-1:0] base, input int s0,
                        input int s1, input int n);
    for (int k = 0; k < n; k++) begin
      put(0, s0 + 2*k, base + W'(2*k));
      put(1, s1 + 2*k, base + W'(2*k + 1));
    end
  endtask

  task automatic apply(input int c);
    valid_0 = sv0[c]; lane_0 = sd0[c];
    valid_1 = sv1[c]; lane_1 = sd1[c];
  endtask

  // Advance reference model with pre-edge inputs, then clock the DUT.
  task automatic step();
    bit c0, c1, a1, pop, go_run, go_idle;
    c0 = valid_0 && !m_sk0;
    c1 = valid_1 && !m_sk1;
    a1 = c1 && (m_run || mq0.size() > 0 || c0);
    pop = m_run && (m_sel ? mq1.size() > 0 : mq0.size() > 0);
    go_run  = !m_run && mq0.size() > 0;
    go_idle = m_run && !valid_0 && !valid_1 &&
              mq0.size() == 0 && mq1.size() == 0 && !m_sel;
    m_vout = pop;
    if (pop) begin
      if (m_sel) m_dout = mq1.pop_front();
      else       m_dout = mq0.pop_front();
      m_sel = !m_sel;
    end
    if (c0) begin
      if (mq0.size() < D) mq0.push_back(lane_0);
      else m_ovf = 1;
    end
    if (a1) begin
      if (mq1.size() < D) mq1.push_back(lane_1);
      else m_ovf = 1;
    end
    m_sk0 = c0;
    m_sk1 = c1;
    if (go_run) m_run = 1;
    else if (go_idle) m_run = 0;
    @(posedge clk_2f);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk_2f);
    #1;
    vec++;
    if (data_out !== '0) begin
      err++; $display("FAIL reset data_out: got %h want 0", data_out);
    end
    vec++;
    if (valid_out !== 1'b0) begin
      err++; $display("FAIL reset valid_out: got %b want 0", valid_out);
    end
    vec++;
    if (overflow !== 1'b0) begin
      err++; $display("FAIL reset overflow: got %b want 0", overflow);
    end
    vec++;
    if (aligned !== 1'b0) begin
      err++; $display("FAIL reset aligned: got %b want 0", aligned);
    end
    @(negedge clk_2f);
    reset = 0;
    model_reset();
  endtask

  task automatic test_basic();
    int first, last;
    bit ok;
    first = -1; last = -1;
    sched_clear();
    stream(32'hA0, 0, 1, 2);
    for (int c = 0; c < 10; c++) begin
      apply(c); step();
      vec++;
      if ({valid_out, aligned, overflow, data_out} !==
          {m_vout, m_run, m_ovf, m_dout}) begin
        err++;
        $display("FAIL basic c%0d: got v%b a%b o%b d%h want v%b a%b o%b d%h",
                 c, valid_out, aligned, overflow, data_out,
                 m_vout, m_run, m_ovf, m_dout);
      end
      if (valid_out) begin
        got.push_back(data_out);
        if (first < 0) first = c;
        last = c;
      end
    end
    exp_q = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    ok = (got.size() == exp_q.size());
    for (int i = 0; i < got.size() && ok; i++) ok = (got[i] === exp_q[i]);
    vec++;
    if (!ok) begin
      err++; $display("FAIL basic order: got %p want %p", got, exp_q);
    end
    vec++;
    if (last - first != 3) begin
      err++; $display("FAIL basic span: got %0d want 3", last - first);
    end
    vec++;
    if (aligned !== 1'b0 || overflow !== 1'b0) begin
      err++;
      $display("FAIL basic idle: got a%b o%b want a0 o0", aligned, overflow);
    end
  endtask

  task automatic test_skew();
    int first, last;
    bit ok;
    first = -1; last = -1;
    sched_clear();
    stream(32'hA0, 0, 4, 4);
    for (int c = 0; c < 20; c++) begin
      apply(c); step();
      vec++;
      if ({valid_out, aligned, overflow, data_out} !==
          {m_vout, m_run, m_ovf, m_dout}) begin
        err++;
        $display("FAIL skew c%0d: got v%b a%b o%b d%h want v%b a%b o%b d%h",
                 c, valid_out, aligned, overflow, data_out,
                 m_vout, m_run, m_ovf, m_dout);
      end
      if (valid_out) begin
        got.push_back(data_out);
        if (first < 0) first = c;
        last = c;
      end
    end
    for (int i = 0; i < 8; i++) exp_q.push_back(32'hA0 + W'(i));
    ok = (got.size() == exp_q.size());
    for (int i = 0; i < got.size() && ok; i++) ok = (got[i] === exp_q[i]);
    vec++;
    if (!ok) begin
      err++; $display("FAIL skew order: got %p want %p", got, exp_q);
    end
    vec++;
    if (last - first + 1 <= 8) begin
      err++; $display("FAIL skew gap: got span %0d want >8", last - first + 1);
    end
    vec++;
    if (overflow !== 1'b0) begin
      err++; $display("FAIL skew overflow: got %b want 0", overflow);
    end
  endtask

  task automatic test_idle_discard();
    bit ok;
    sched_clear();
    put(1, 0, 32'hB1);
    stream(32'hA0, 4, 5, 2);
    for (int c = 0; c < 14; c++) begin
      apply(c); step();
      vec++;
      if ({valid_out, aligned, overflow, data_out} !==
          {m_vout, m_run, m_ovf, m_dout}) begin
        err++;
        $display("FAIL discard c%0d: got v%b a%b o%b d%h want v%b a%b o%b d%h",
                 c, valid_out, aligned, overflow, data_out,
                 m_vout, m_run, m_ovf, m_dout);
      end
      if (valid_out) got.push_back(data_out);
    end
    exp_q = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    ok = (got.size() == exp_q.size());
    for (int i = 0; i < got.size() && ok; i++) ok = (got[i] === exp_q[i]);
    vec++;
    if (!ok || overflow !== 1'b0) begin
      err++;
      $display("FAIL discard stream: got %p o%b want %p o0",
               got, overflow, exp_q);
    end
  endtask

  task automatic test_overflow();
    sched_clear();
    for (int k = 0; k < 6; k++) put(0, 2*k, 32'hA0 + W'(2*k));
    for (int c = 0; c < 20; c++) begin
      apply(c); step();
      vec++;
      if ({valid_out, aligned, overflow, data_out} !==
          {m_vout, m_run, m_ovf, m_dout}) begin
        err++;
        $display("FAIL ovf c%0d: got v%b a%b o%b d%h want v%b a%b o%b d%h",
                 c, valid_out, aligned, overflow, data_out,
                 m_vout, m_run, m_ovf, m_dout);
      end
      if (valid_out) got.push_back(data_out);
    end
    vec++;
    if (got.size() != 1 || got[0] !== 32'hA0) begin
      err++; $display("FAIL ovf output: got %p want A0 only", got);
    end
    vec++;
    if (overflow !== 1'b1) begin
      err++; $display("FAIL ovf sticky: got %b want 1", overflow);
    end
    reset = 1;
    #2;
    vec++;
    if (overflow !== 1'b0 || aligned !== 1'b0) begin
      err++;
      $display("FAIL ovf clear: got o%b a%b want o0 a0", overflow, aligned);
    end
    @(negedge clk_2f);
    reset = 0;
    model_reset();
  endtask

  task automatic test_reset_mid();
    bit ok;
    sched_clear();
    for (int k = 0; k < 4; k++) put(0, 2*k, 32'hA0 + W'(2*k));
    for (int c = 0; c < 7; c++) begin
      apply(c); step();
      vec++;
      if ({valid_out, aligned, overflow, data_out} !==
          {m_vout, m_run, m_ovf, m_dout}) begin
        err++;
        $display("FAIL rstmid c%0d: got v%b a%b o%b d%h want v%b a%b o%b d%h",
                 c, valid_out, aligned, overflow, data_out,
                 m_vout, m_run, m_ovf, m_dout);
      end
    end
    reset = 1;
    valid_0 = 0; valid_1 = 0; lane_0 = '0; lane_1 = '0;
    #1;
    vec++;
    if ({valid_out, aligned, data_out} !== {1'b0, 1'b0, 32'h0}) begin
      err++;
      $display("FAIL rstmid async: got v%b a%b d%h want v0 a0 d0",
               valid_out, aligned, data_out);
    end
    @(negedge clk_2f);
    reset = 0;
    model_reset();
    sched_clear();
    stream(32'hC0, 0, 1, 1);
    for (int c = 0; c < 10; c++) begin
      apply(c); step();
      vec++;
      if ({valid_out, aligned, overflow, data_out} !==
          {m_vout, m_run, m_ovf, m_dout}) begin
        err++;
        $display("FAIL restart c%0d: got v%b a%b o%b d%h want v%b a%b o%b d%h",
                 c, valid_out, aligned, overflow, data_out,
                 m_vout, m_run, m_ovf, m_dout);
      end
      if (valid_out) got.push_back(data_out);
    end
    exp_q = '{32'hC0, 32'hC1};
    ok = (got.size() == exp_q.size());
    for (int i = 0; i < got.size() && ok; i++) ok = (got[i] === exp_q[i]);
    vec++;
    if (!ok) begin
      err++; $display("FAIL restart stream: got %p want %p", got, exp_q);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] d0[8];
    logic [W-1:0] d1[8];
    int n, lag;
    bit ok;
    for (int r = 0; r < 8; r++) begin
      sched_clear();
      n   = $urandom_range(1, 5);
      lag = $urandom_range(0, 3);
      for (int k = 0; k < n; k++) begin
        d0[k] = $urandom;
        d1[k] = $urandom;
        put(0, 2*k, d0[k]);
        put(1, lag + 2*k, d1[k]);
        exp_q.push_back(d0[k]);
        exp_q.push_back(d1[k]);
      end
      for (int c = 0; c < 2*n + lag + 8; c++) begin
        apply(c); step();
        vec++;
        if ({valid_out, aligned, overflow, data_out} !==
            {m_vout, m_run, m_ovf, m_dout}) begin
          err++;
          $display("FAIL rand r%0d c%0d: got v%b a%b o%b d%h want v%b a%b o%b d%h",
                   r, c, valid_out, aligned, overflow, data_out,
                   m_vout, m_run, m_ovf, m_dout);
        end
        if (valid_out) got.push_back(data_out);
      end
      ok = (got.size() == exp_q.size());
      for (int i = 0; i < got.size() && ok; i++) ok = (got[i] === exp_q[i]);
      vec++;
      if (!ok) begin
        err++;
        $display("FAIL rand r%0d stream: got %0d words want %0d",
                 r, got.size(), exp_q.size());
      end
      vec++;
      if (aligned !== 1'b0 || overflow !== 1'b0) begin
        err++;
        $display("FAIL rand r%0d idle: got a%b o%b want a0 o0",
                 r, aligned, overflow);
      end
    end
  endtask

  initial begin
    model_reset();
    sched_clear();
    test_reset();
    test_basic();
    test_skew();
    test_idle_discard();
    test_random();
    test_overflow();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
